enc_position_ctrl: RTL and testbench

Controller behind the Pmod ENC decoder (`enc`).
- Consumes the decoder's direction pulses (dir0 = counter-clockwise step, dir1 = clockwise step) and the encoder push-button and slide switch.
- Maintains a bounded position value with selectable wrap or saturate behaviour, debounced button preset and step reporting.
- Feeds display or PWM consumers; replaces ad-hoc per-direction counters clocked from the pulses themselves.

---
 rtl/enc_pkg.sv | 16 +
 rtl/enc_btn_debounce.sv | 81 ++++++++
 rtl/enc_position_ctrl.sv | 136 +++++++++++++
 tb/tb_enc_position_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared definitions for the encoder position controller.
package enc_pkg;

    // Button debounce FSM states.
    typedef enum logic [1:0] {
        RELEASED     = 2'b00,
        PRESS_WAIT   = 2'b01,
        PRESSED      = 2'b10,
        RELEASE_WAIT = 2'b11
    } deb_state_t;

    // step_dir encoding.
    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

endpackage

// File: rtl/enc_btn_debounce.sv
// Push-button synchroniser and debouncer; emits one press pulse per
// accepted press, none while held and none on release.
module enc_btn_debounce
    import enc_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic btn_meta;
    logic btn_sync;
    logic [CNT_W-1:0] cnt;
    deb_state_t state;
    deb_state_t next_state;

    // Two-flop synchroniser for the raw button.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_meta <= btn;
            btn_sync <= btn_meta;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RELEASED;
        end else begin
            state <= next_state;
        end
    end

    // Stability counter: cleared on entering a wait state, counts while waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if ((state == RELEASED && btn_sync) || (state == PRESSED && !btn_sync)) begin
            cnt <= '0;
        end else if ((state == PRESS_WAIT || state == RELEASE_WAIT) && cnt != CNT_LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            RELEASED: begin
                if (btn_sync) next_state = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!btn_sync)             next_state = RELEASED;
                else if (cnt == CNT_LAST)  next_state = PRESSED;
            end
            PRESSED: begin
                if (!btn_sync) next_state = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (btn_sync)              next_state = PRESSED;
                else if (cnt == CNT_LAST)  next_state = RELEASED;
            end
            default: next_state = RELEASED;
        endcase
    end

    // Press pulse on the single PRESS_WAIT -> PRESSED transition.
    always_comb begin
        press = (state == PRESS_WAIT) && btn_sync && (cnt == CNT_LAST);
    end

endmodule

// File: rtl/enc_position_ctrl.sv
// Bounded position register driven by Pmod ENC direction pulses, with
// wrap/saturate arithmetic, enable switch and debounced button preset.
module enc_position_ctrl #(
    parameter int unsigned W          = 8,
    parameter int unsigned MIN_POS    = 0,
    parameter int unsigned MAX_POS    = 255,
    parameter int unsigned STEP       = 1,
    parameter int unsigned PRESET     = 0,
    parameter int unsigned DEB_CYCLES = 100000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         dir0,
    input  logic         dir1,
    input  logic         btn,
    input  logic         sw,
    input  logic         wrap,
    output logic [W-1:0] position,
    output logic         step_pulse,
    output logic         step_dir,
    output logic         at_min,
    output logic         at_max,
    output logic         preset_pulse
);

    import enc_pkg::*;

    localparam logic [W:0]   MAX_X    = (W+1)'(MAX_POS);
    localparam logic [W:0]   STEP_X   = (W+1)'(STEP);
    localparam logic [W:0]   RANGE_X  = (W+1)'(MAX_POS - MIN_POS + 1);
    localparam logic [W:0]   LOW_X    = (W+1)'(MIN_POS + STEP);
    localparam logic [W-1:0] MIN_V    = W'(MIN_POS);
    localparam logic [W-1:0] MAX_V    = W'(MAX_POS);
    localparam logic [W-1:0] PRESET_V = W'(PRESET);

    logic dir0_meta, dir0_sync, dir0_prev, armed0, rise0, req0;
    logic dir1_meta, dir1_sync, dir1_prev, armed1, rise1, req1;
    logic sw_meta, sw_sync;
    logic [1:0] valid_q;
    logic press;
    logic [W:0] pos_x;
    logic [W:0] cw_sum;
    logic [W-1:0] next_pos;

    enc_btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .press(press)
    );

    // Two-flop synchronisers for the direction pulses and enable switch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir0_meta <= 1'b0;
            dir0_sync <= 1'b0;
            dir1_meta <= 1'b0;
            dir1_sync <= 1'b0;
            sw_meta   <= 1'b0;
            sw_sync   <= 1'b0;
        end else begin
            dir0_meta <= dir0;
            dir0_sync <= dir0_meta;
            dir1_meta <= dir1;
            dir1_sync <= dir1_meta;
            sw_meta   <= sw;
            sw_sync   <= sw_meta;
        end
    end

    // A direction only arms once a real (post-reset) low sample is seen, so a
    // line held high across reset is not mistaken for a fresh edge.
    assign rise0 = dir0_sync & ~dir0_prev & armed0;
    assign rise1 = dir1_sync & ~dir1_prev & armed1;

    // Edge history, arming, and registered step requests (coincident edges cancel).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir0_prev <= 1'b0;
            dir1_prev <= 1'b0;
            valid_q   <= '0;
            armed0    <= 1'b0;
            armed1    <= 1'b0;
            req0      <= 1'b0;
            req1      <= 1'b0;
        end else begin
            dir0_prev <= dir0_sync;
            dir1_prev <= dir1_sync;
            valid_q   <= {valid_q[0], 1'b1};
            armed0    <= armed0 | (valid_q[1] & ~dir0_sync);
            armed1    <= armed1 | (valid_q[1] & ~dir1_sync);
            req0      <= rise0 & ~rise1 & sw_sync;
            req1      <= rise1 & ~rise0 & sw_sync;
        end
    end

    // Candidate position for a pending step, computed in W+1 bits.
    always_comb begin
        pos_x    = {1'b0, position};
        cw_sum   = pos_x + STEP_X;
        next_pos = position;
        if (req1) begin
            if (cw_sum > MAX_X) next_pos = wrap ? W'(cw_sum - RANGE_X) : MAX_V;
            else                next_pos = W'(cw_sum);
        end else begin
            if (pos_x < LOW_X)  next_pos = wrap ? W'(pos_x + RANGE_X - STEP_X) : MIN_V;
            else                next_pos = W'(pos_x - STEP_X);
        end
    end

    // Position register; a button preset wins over a same-cycle step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            position     <= PRESET_V;
            step_pulse   <= 1'b0;
            step_dir     <= DIR_CCW;
            preset_pulse <= 1'b0;
        end else begin
            step_pulse   <= 1'b0;
            preset_pulse <= press;
            if (press) begin
                position <= PRESET_V;
            end else if (req0 || req1) begin
                position   <= next_pos;
                step_pulse <= 1'b1;
                step_dir   <= req1 ? DIR_CW : DIR_CCW;
            end
        end
    end

    assign at_min = (position == MIN_V);
    assign at_max = (position == MAX_V);

endmodule

// File: tb/tb_enc_position_ctrl.sv
// Self-checking bench for enc_position_ctrl: a scoreboard of expected
// step/preset pulses plus per-scenario direct checks.
module tb_enc_position_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default range, short debounce
    logic       rst, dir0, dir1, btn, sw, wrap;
    logic [7:0] position;
    logic       step_pulse, step_dir, at_min, at_max, preset_pulse;

    // DUT B: narrow range 10..20, step 3, preset 19
    logic       rst_b, dir0_b, dir1_b, btn_b, sw_b, wrap_b;
    logic [7:0] position_b;
    logic       step_pulse_b, step_dir_b, at_min_b, at_max_b, preset_pulse_b;

    enc_position_ctrl #(
        .W(8), .MIN_POS(0), .MAX_POS(255), .STEP(1), .PRESET(0), .DEB_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst), .dir0(dir0), .dir1(dir1), .btn(btn), .sw(sw), .wrap(wrap),
        .position(position), .step_pulse(step_pulse), .step_dir(step_dir),
        .at_min(at_min), .at_max(at_max), .preset_pulse(preset_pulse)
    );

    enc_position_ctrl #(
        .W(8), .MIN_POS(10), .MAX_POS(20), .STEP(3), .PRESET(19), .DEB_CYCLES(4)
    ) dut_b (
        .clk(clk), .rst(rst_b), .dir0(dir0_b), .dir1(dir1_b), .btn(btn_b), .sw(sw_b), .wrap(wrap_b),
        .position(position_b), .step_pulse(step_pulse_b), .step_dir(step_dir_b),
        .at_min(at_min_b), .at_max(at_max_b), .preset_pulse(preset_pulse_b)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int pulses_b = 0;

    typedef struct {
        bit         preset;
        logic [7:0] pos;
        logic       dir;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (step_pulse_b === 1'b1) pulses_b++;

    // Scoreboard monitor: every pulse of DUT A must match the oldest expectation.
    always @(negedge clk) begin
        if (step_pulse === 1'b1 || preset_pulse === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected: step_pulse=%b preset_pulse=%b position=%0d cycle=%0d, expected no pulse",
                         step_pulse, preset_pulse, position, cyc);
            end else begin
                e = sb.pop_front();
                if (preset_pulse !== e.preset || step_pulse !== !e.preset || position !== e.pos ||
                    (!e.preset && step_dir !== e.dir) || cyc != e.cyc) begin
                    miscompares++;
                    $display("FAIL sb_pulse: got step=%b preset=%b pos=%0d dir=%b cyc=%0d, expected preset=%b pos=%0d dir=%b cyc=%0d",
                             step_pulse, preset_pulse, position, step_dir, cyc, e.preset, e.pos, e.dir, e.cyc);
                end
            end
        end
    end

    // One detent on DUT A: 4 cycles high, 4 low; optionally expect a step.
    task automatic pulse_a(input bit cw, input bit expect_step, input logic [7:0] exp_pos);
        exp_t x;
        if (expect_step) begin
            x.preset = 1'b0; x.pos = exp_pos; x.dir = cw; x.cyc = cyc + 4;
            sb.push_back(x);
        end
        if (cw) dir1 = 1'b1; else dir0 = 1'b1;
        repeat (4) @(negedge clk);
        dir0 = 1'b0; dir1 = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_b(input bit cw);
        if (cw) dir1_b = 1'b1; else dir0_b = 1'b1;
        repeat (4) @(negedge clk);
        dir0_b = 1'b0; dir1_b = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; dir0 = 1'b0; dir1 = 1'b0; btn = 1'b0; sw = 1'b0; wrap = 1'b0;
        rst_b = 1'b1; dir0_b = 1'b0; dir1_b = 1'b0; btn_b = 1'b0; sw_b = 1'b0; wrap_b = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({position, step_pulse, step_dir, preset_pulse, at_min, at_max} !== {8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: got pos=%0d sp=%b dir=%b pp=%b min=%b max=%b, expected pos=0 sp=0 dir=0 pp=0 min=1 max=0",
                     position, step_pulse, step_dir, preset_pulse, at_min, at_max);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_cw_steps;
        sw = 1'b1; wrap = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) pulse_a(1'b1, 1'b1, 8'(i + 1));
        vectors++;
        if (position !== 8'd3 || step_dir !== 1'b1 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL cw_steps: got pos=%0d dir=%b pending=%0d, expected pos=3 dir=1 pending=0",
                     position, step_dir, sb.size());
        end
    endtask

    task automatic test_bounds;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        wrap = 1'b0;
        pulse_a(1'b0, 1'b1, 8'd0);
        vectors++;
        if (position !== 8'd0 || at_min !== 1'b1 || step_dir !== 1'b0) begin
            miscompares++;
            $display("FAIL ccw_saturate: got pos=%0d min=%b dir=%b, expected pos=0 min=1 dir=0", position, at_min, step_dir);
        end
        wrap = 1'b1;
        pulse_a(1'b0, 1'b1, 8'd255);
        vectors++;
        if (position !== 8'd255 || at_max !== 1'b1 || at_min !== 1'b0) begin
            miscompares++;
            $display("FAIL ccw_wrap: got pos=%0d max=%b min=%b, expected pos=255 max=1 min=0", position, at_max, at_min);
        end
        wrap = 1'b0;
        pulse_a(1'b1, 1'b1, 8'd255);
        vectors++;
        if (position !== 8'd255 || step_dir !== 1'b1) begin
            miscompares++;
            $display("FAIL cw_saturate: got pos=%0d dir=%b, expected pos=255 dir=1", position, step_dir);
        end
        wrap = 1'b1;
        pulse_a(1'b1, 1'b1, 8'd0);
        vectors++;
        if (position !== 8'd0 || at_min !== 1'b1) begin
            miscompares++;
            $display("FAIL cw_wrap: got pos=%0d min=%b, expected pos=0 min=1", position, at_min);
        end
    endtask

    task automatic test_simultaneous_and_disable;
        dir0 = 1'b1; dir1 = 1'b1;
        repeat (4) @(negedge clk);
        dir0 = 1'b0; dir1 = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if (position !== 8'd0 || step_dir !== 1'b1) begin
            miscompares++;
            $display("FAIL simultaneous: got pos=%0d dir=%b, expected pos=0 dir=1", position, step_dir);
        end
        sw = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 5; i++) pulse_a(1'b1, 1'b0, 8'd0);
        vectors++;
        if (position !== 8'd0) begin
            miscompares++;
            $display("FAIL sw_disabled: got pos=%0d, expected pos=0", position);
        end
        sw = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_button;
        exp_t x;
        pulse_a(1'b1, 1'b1, 8'd1);
        for (int i = 0; i < 5; i++) begin
            btn = 1'b1; repeat (2) @(negedge clk);
            btn = 1'b0; repeat (2) @(negedge clk);
        end
        vectors++;
        if (position !== 8'd1) begin
            miscompares++;
            $display("FAIL bounce_rejected: got pos=%0d, expected pos=1", position);
        end
        // accepted press lands 3 + DEB_CYCLES edges after btn rises
        x.preset = 1'b1; x.pos = 8'd0; x.dir = 1'b1; x.cyc = cyc + 7;
        sb.push_back(x);
        btn = 1'b1;
        repeat (3) @(negedge clk);
        dir1 = 1'b1;                  // its step would land on the preset edge
        repeat (7) @(negedge clk);
        btn = 1'b0;
        repeat (10) @(negedge clk);
        dir1 = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if (position !== 8'd0 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL button_preset: got pos=%0d pending=%0d, expected pos=0 pending=0", position, sb.size());
        end
    endtask

    task automatic test_reset_mid_step;
        pulse_a(1'b1, 1'b1, 8'd1);
        dir1 = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (position !== 8'd0 || step_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got pos=%0d sp=%b, expected pos=0 sp=0", position, step_pulse);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        vectors++;
        if (position !== 8'd0) begin
            miscompares++;
            $display("FAIL held_after_reset: got pos=%0d, expected pos=0", position);
        end
        dir1 = 1'b0;
        repeat (4) @(negedge clk);
        pulse_a(1'b1, 1'b1, 8'd1);
        vectors++;
        if (position !== 8'd1 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL rearm_after_reset: got pos=%0d pending=%0d, expected pos=1 pending=0", position, sb.size());
        end
    endtask

    task automatic test_small_range;
        int p0;
        sw_b = 1'b1; wrap_b = 1'b1;
        vectors++;
        if (position_b !== 8'd19) begin
            miscompares++;
            $display("FAIL b_reset: got pos=%0d, expected pos=19", position_b);
        end
        rst_b = 1'b0;
        repeat (4) @(negedge clk);
        p0 = pulses_b;
        pulse_b(1'b1);
        vectors++;
        if (position_b !== 8'd11 || pulses_b != p0 + 1 || step_dir_b !== 1'b1) begin
            miscompares++;
            $display("FAIL b_cw_wrap: got pos=%0d pulses=%0d dir=%b, expected pos=11 pulses=%0d dir=1",
                     position_b, pulses_b, step_dir_b, p0 + 1);
        end
        pulse_b(1'b0);
        vectors++;
        if (position_b !== 8'd19) begin
            miscompares++;
            $display("FAIL b_ccw_wrap: got pos=%0d, expected pos=19", position_b);
        end
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0; wrap_b = 1'b0;
        repeat (4) @(negedge clk);
        pulse_b(1'b1);
        vectors++;
        if (position_b !== 8'd20 || at_max_b !== 1'b1) begin
            miscompares++;
            $display("FAIL b_cw_saturate: got pos=%0d max=%b, expected pos=20 max=1", position_b, at_max_b);
        end
        pulse_b(1'b0);
        vectors++;
        if (position_b !== 8'd17 || at_min_b !== 1'b0 || at_max_b !== 1'b0) begin
            miscompares++;
            $display("FAIL b_ccw_step: got pos=%0d min=%b max=%b, expected pos=17 min=0 max=0",
                     position_b, at_min_b, at_max_b);
        end
    endtask

    initial begin
        test_reset;
        test_cw_steps;
        test_bounds;
        test_simultaneous_and_disable;
        test_button;
        test_reset_mid_step;
        test_small_range;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: got %0d pending expectations, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
